// File: rtl/icache_pkg.sv
// -----------------------------------------------------------------------------
// icache_pkg
// Shared definitions for the instruction cache slice: the default geometry
// (INDEX_W / TAG_W), the true/false constants used across the codebase and the
// cache controller state type.
// Ports: none (package).
// -----------------------------------------------------------------------------
package icache_pkg;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    // 256 one-word lines, tag from address bits [17:10]
    localparam int ICACHE_INDEX_W = 8;
    localparam int ICACHE_TAG_W   = 8;

    typedef enum logic {
        IDLE = 1'b0,
        MISS = 1'b1
    } icache_state_e;

endpackage

// File: rtl/icache_if.sv
// -----------------------------------------------------------------------------
// icache_if
// Bundles the fetch-unit side and the memory-controller side of the
// instruction cache.
//   if_valid/if_pc   fetch request and address
//   if_ready/if_inst zero-cycle hit indication and instruction word
//   mc_valid/mc_addr fetch request to the memory controller
//   mc_enable/mc_din one-cycle completion pulse and fetched word
// Modports: slave = the cache, master = fetch unit + memory controller.
// -----------------------------------------------------------------------------
interface icache_if;

    logic        if_valid;
    logic [31:0] if_pc;
    logic        if_ready;
    logic [31:0] if_inst;
    logic        mc_valid;
    logic [31:0] mc_addr;
    logic        mc_enable;
    logic [31:0] mc_din;

    modport slave (
        input  if_valid, if_pc, mc_enable, mc_din,
        output if_ready, if_inst, mc_valid, mc_addr
    );

    modport master (
        output if_valid, if_pc, mc_enable, mc_din,
        input  if_ready, if_inst, mc_valid, mc_addr
    );

endinterface

// File: rtl/icache_array.sv
// -----------------------------------------------------------------------------
// icache_array
// Tag, data and valid storage for the direct-mapped cache. One asynchronous
// read port addressed by index, one synchronous write port.
//   clk, rst     clock, synchronous active-high reset (clears valid bits only)
//   rd_index_i   read index; rd_valid_o/rd_tag_o/rd_data_o the addressed line
//   wr_en_i      write strobe; wr_index_i/wr_tag_i/wr_data_i the new line
// -----------------------------------------------------------------------------
module icache_array
    import icache_pkg::*;
#(
    parameter int INDEX_W = ICACHE_INDEX_W,
    parameter int TAG_W   = ICACHE_TAG_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [INDEX_W-1:0] rd_index_i,
    output logic               rd_valid_o,
    output logic [TAG_W-1:0]   rd_tag_o,
    output logic [31:0]        rd_data_o,
    input  logic               wr_en_i,
    input  logic [INDEX_W-1:0] wr_index_i,
    input  logic [TAG_W-1:0]   wr_tag_i,
    input  logic [31:0]        wr_data_i
);

    localparam int LINES = 1 << INDEX_W;

    logic [LINES-1:0] valid_q;
    logic [TAG_W-1:0] tag_q  [LINES];
    logic [31:0]      data_q [LINES];

    // Valid bits are the only state that must be cleared; a line becomes
    // valid only when it is filled.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else if (wr_en_i) begin
            valid_q[wr_index_i] <= TRUE;
        end
    end

    // Tag and data carry no reset; they are qualified by the valid bit.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            tag_q[wr_index_i]  <= wr_tag_i;
            data_q[wr_index_i] <= wr_data_i;
        end
    end

    assign rd_valid_o = valid_q[rd_index_i];
    assign rd_tag_o   = tag_q[rd_index_i];
    assign rd_data_o  = data_q[rd_index_i];

endmodule

// File: rtl/icache.sv
// -----------------------------------------------------------------------------
// icache
// Direct-mapped instruction cache, one 32-bit word per line, with a
// zero-cycle hit path and a two-state (IDLE/MISS) refill controller.
//   clk, rst  clock, synchronous active-high reset
//   rdy       global ready; low pauses the controller and the array
//   bus       icache_if.slave: fetch-unit and memory-controller signals
// -----------------------------------------------------------------------------
module icache
    import icache_pkg::*;
#(
    parameter int INDEX_W = ICACHE_INDEX_W,
    parameter int TAG_W   = ICACHE_TAG_W
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     rdy,
    icache_if.slave  bus
);

    icache_state_e      state_q;
    logic [29:0]        mc_word_q;

    logic [INDEX_W-1:0] rd_index;
    logic [TAG_W-1:0]   pc_tag;
    logic               rd_valid;
    logic [TAG_W-1:0]   rd_tag;
    logic [31:0]        rd_data;
    logic               hit;
    logic               fill_en;
    logic               unused_pc;

    assign rd_index  = bus.if_pc[INDEX_W+1:2];
    assign pc_tag    = bus.if_pc[INDEX_W+TAG_W+1:INDEX_W+2];
    assign unused_pc = ^bus.if_pc[1:0];

    assign hit = rd_valid && (rd_tag == pc_tag);

    assign bus.if_ready = (state_q == IDLE) && bus.if_valid && hit;
    assign bus.if_inst  = rd_data;

    // Drop mc_valid already in the completion cycle so the controller never
    // sees a request in the cycle after its pulse and starts a second fetch.
    assign bus.mc_valid = (state_q == MISS) && !bus.mc_enable;
    assign bus.mc_addr  = {mc_word_q, 2'b00};

    // A reset arriving together with the completion pulse abandons the fill.
    assign fill_en = (state_q == MISS) && rdy && bus.mc_enable && !rst;

    // Refill controller: a miss latches the word address and waits for the
    // controller's pulse; it is not cancelled by if_valid/if_pc changes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            mc_word_q <= '0;
        end else if (rdy) begin
            case (state_q)
                IDLE: begin
                    if (bus.if_valid && !hit) begin
                        mc_word_q <= bus.if_pc[31:2];
                        state_q   <= MISS;
                    end
                end
                MISS: begin
                    if (bus.mc_enable) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    icache_array #(
        .INDEX_W (INDEX_W),
        .TAG_W   (TAG_W)
    ) u_array (
        .clk        (clk),
        .rst        (rst),
        .rd_index_i (rd_index),
        .rd_valid_o (rd_valid),
        .rd_tag_o   (rd_tag),
        .rd_data_o  (rd_data),
        .wr_en_i    (fill_en),
        .wr_index_i (mc_word_q[INDEX_W-1:0]),
        .wr_tag_i   (mc_word_q[INDEX_W+TAG_W-1:INDEX_W]),
        .wr_data_i  (bus.mc_din)
    );

endmodule
